generic_bus_sram_responder: RTL and testbench



---
 rtl/generic_bus_sram_responder.sv | 135 +++++++++++++
 tb/tb_generic_bus_sram_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/generic_bus_sram_responder.sv
// Word-addressed SRAM slave for the generic data bus: wait states, byte-enabled writes, range errors.
// Define GBUS_RESP_RANDOM_STALL_EN to add 0-3 LFSR-driven extra wait cycles per transaction.
module generic_bus_sram_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        error
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = $clog2(LATENCY + 4);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_count, w_count_nxt, w_count_load;
  logic [31:0]     r_addr, r_wdata;
  logic [3:0]      r_be;
  logic            r_ren, r_wen, r_err;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [31:0]     w_off;
  logic            w_in_range, w_req, w_changed, w_accept;

  assign w_off      = addr - BASE_ADDR;
  assign w_in_range = (addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
  assign w_req      = ren | wen;
  assign w_changed  = (addr != r_addr) || (ren != r_ren) || (wen != r_wen);

`ifdef GBUS_RESP_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_count_load = CW'(LATENCY - 1) + CW'(r_lfsr[1:0]);
`else
  assign w_count_load = CW'(LATENCY - 1);
`endif

  // A changed address/op while waiting is treated as a fresh acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          w_count_nxt = w_count_load;
          w_state_nxt = (w_count_load == '0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
        end else if (w_changed) begin
          w_accept    = 1'b1;
          w_count_nxt = w_count_load;
          w_state_nxt = (w_count_load == '0) ? S_RESP : S_WAIT;
        end else if (r_count <= CW'(1)) begin
          w_count_nxt = '0;
          w_state_nxt = S_RESP;
        end else begin
          w_count_nxt = r_count - CW'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_be    <= byte_en;
        r_ren   <= ren;
        r_wen   <= wen;
        r_err   <= !w_in_range || (ren && wen);
        r_idx   <= w_off[AW+1:2];
      end
    end
  end

  // Commit happens on the edge that ends RESP; a reset during RESP drops it.
  always_ff @(posedge CLK) begin
    if (r_state == S_RESP && r_wen && !r_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign busy  = (r_state != S_RESP);
  assign error = (r_state == S_RESP) && r_err;
  assign rdata = (r_state == S_RESP && r_ren && !r_err) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Directed self-checking bench for generic_bus_sram_responder (DEPTH_WORDS=1024, BASE=0, LATENCY=2).
module tb_generic_bus_sram_responder;

  localparam int MIN_LAT = 2;
`ifdef GBUS_RESP_RANDOM_STALL_EN
  localparam int MAX_LAT = 5;
`else
  localparam int MAX_LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  byte_en = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] rdata;
  logic        busy;
  logic        error;

  int n_vec = 0;
  int n_err = 0;

  generic_bus_sram_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .LATENCY    (2)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .addr   (addr),
    .wdata  (wdata),
    .byte_en(byte_en),
    .ren    (ren),
    .wen    (wen),
    .rdata  (rdata),
    .busy   (busy),
    .error  (error)
  );

  always #5 CLK = ~CLK;

  // Drives one request from an IDLE cycle and returns completion latency (0 on timeout).
  task automatic run_txn(input logic i_ren, input logic i_wen, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output int lat, output logic [31:0] rd, output logic er);
    ren = i_ren; wen = i_wen; addr = a; wdata = d; byte_en = be;
    lat = 0; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK); #1;
      if (!busy) begin
        lat = c; rd = rdata; er = error;
        break;
      end
    end
    ren = 1'b0; wen = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    #12;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", busy); end
    n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL reset_error got %b want 0", error); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd; logic er;
    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    n_vec++; if (lat < MIN_LAT || lat > MAX_LAT) begin n_err++; $display("FAIL wr_latency got %0d want %0d..%0d", lat, MIN_LAT, MAX_LAT); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL wr_error got %b want 0", er); end
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (lat < MIN_LAT || lat > MAX_LAT) begin n_err++; $display("FAIL rd_latency got %0d want %0d..%0d", lat, MIN_LAT, MAX_LAT); end
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", rd); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL rd_error got %b want 0", er); end
    n_vec++; if (busy !== 1'b1 || rdata !== 32'h0) begin n_err++; $display("FAIL idle_after_resp got busy=%b rdata=%h want 1/0", busy, rdata); end
  endtask

  task automatic test_byte_en;
    int lat; logic [31:0] rd; logic er;
    run_txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er);
    run_txn(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er);
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h11BB33DD) begin n_err++; $display("FAIL byte_en_merge got %h want 11bb33dd", rd); end
    run_txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    n_vec++; if (er !== 1'b0 || lat < MIN_LAT || lat > MAX_LAT) begin n_err++; $display("FAIL byte_en_zero_cpl got err=%b lat=%0d want 0/%0d..%0d", er, lat, MIN_LAT, MAX_LAT); end
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h11BB33DD) begin n_err++; $display("FAIL byte_en_zero_noop got %h want 11bb33dd", rd); end
  endtask

  task automatic test_range_error;
    int lat; logic [31:0] rd; logic er;
    run_txn(1'b0, 1'b1, 32'h0, 32'hA5A50001, 4'hF, lat, rd, er);
    run_txn(1'b0, 1'b1, 32'hFFC, 32'h5A5A0FFC, 4'hF, lat, rd, er);
    run_txn(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_read_error got %b want 1", er); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL oor_read_rdata got %h want 0", rd); end
    n_vec++; if (lat < MIN_LAT || lat > MAX_LAT) begin n_err++; $display("FAIL oor_latency got %0d want %0d..%0d", lat, MIN_LAT, MAX_LAT); end
    run_txn(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL oor_write_error got %b want 1", er); end
    run_txn(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (rd !== 32'hA5A50001) begin n_err++; $display("FAIL oor_word0_intact got %h want a5a50001", rd); end
    run_txn(1'b1, 1'b0, 32'hFFF, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h5A5A0FFC || er !== 1'b0) begin n_err++; $display("FAIL last_word_read got %h err=%b want 5a5a0ffc/0", rd, er); end
  endtask

  task automatic test_both_ops;
    int lat; logic [31:0] rd; logic er;
    run_txn(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    n_vec++; if (er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL both_ops_cpl got err=%b rdata=%h want 1/0", er, rd); end
    run_txn(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (rd !== 32'hA5A50001) begin n_err++; $display("FAIL both_ops_mem got %h want a5a50001", rd); end
  endtask

  task automatic test_abort;
    int lat; logic [31:0] rd; logic er; logic seen_cpl;
    addr = 32'h0; wdata = 32'h12345678; byte_en = 4'hF; wen = 1'b1;
    @(posedge CLK); #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_in_wait got busy=%b want 1", busy); end
    wen = 1'b0;
    seen_cpl = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      if (busy !== 1'b1) seen_cpl = 1'b1;
    end
    n_vec++; if (seen_cpl) begin n_err++; $display("FAIL abort_no_cpl got a completion want none"); end
    run_txn(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (rd !== 32'hA5A50001) begin n_err++; $display("FAIL abort_mem got %h want a5a50001", rd); end
  endtask

  task automatic test_restart;
    int lat; logic [31:0] rd; logic er;
    run_txn(1'b0, 1'b1, 32'h14, 32'hCAFE0014, 4'hF, lat, rd, er);
    addr = 32'h10; ren = 1'b1;
    @(posedge CLK); #1;
    addr = 32'h14;
    lat = 0; rd = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK); #1;
      if (!busy) begin lat = c; rd = rdata; break; end
    end
    ren = 1'b0;
    @(posedge CLK); #1;
    n_vec++; if (lat < MIN_LAT || lat > MAX_LAT + 1) begin n_err++; $display("FAIL restart_latency got %0d want %0d..%0d after change", lat, MIN_LAT, MAX_LAT + 1); end
    n_vec++; if (rd !== 32'hCAFE0014) begin n_err++; $display("FAIL restart_data got %h want cafe0014", rd); end
  endtask

  task automatic test_reset_mid_write;
    int lat; logic [31:0] rd; logic er;
    addr = 32'h10; wdata = 32'h0BADF00D; byte_en = 4'hF; wen = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b1 || error !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL mid_reset_outputs got busy=%b err=%b rdata=%h want 1/0/0", busy, error, rdata); end
    #2;
    wen = 1'b0;
    nRST = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL mid_reset_no_commit got %h want deadbeef", rd); end
  endtask

`ifdef GBUS_RESP_RANDOM_STALL_EN
  task automatic test_random_stall;
    int lat; logic [31:0] rd; logic er;
    logic [31:0] sb [16];
    logic [3:0] seen;
    logic [31:0] d;
    logic [3:0] be;
    int idx;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = $urandom;
      run_txn(1'b0, 1'b1, 32'h200 + 32'(i * 4), sb[i], 4'hF, lat, rd, er);
    end
    for (int t = 0; t < 200; t++) begin
      idx = $urandom_range(0, 15);
      d   = $urandom;
      be  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        run_txn(1'b0, 1'b1, 32'h200 + 32'(idx * 4), d, be, lat, rd, er);
        for (int k = 0; k < 4; k++) if (be[k]) sb[idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        run_txn(1'b1, 1'b0, 32'h200 + 32'(idx * 4), 32'h0, 4'h0, lat, rd, er);
        n_vec++; if (rd !== sb[idx]) begin n_err++; $display("FAIL rand_data[%0d] got %h want %h", t, rd, sb[idx]); end
      end
      n_vec++; if (lat < 2 || lat > 5 || er !== 1'b0) begin n_err++; $display("FAIL rand_cpl[%0d] got lat=%0d err=%b want 2..5/0", t, lat, er); end
      if (lat >= 2 && lat <= 5) seen[lat-2] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (seen[k] !== 1'b1) begin n_err++; $display("FAIL rand_stall_seen[%0d] got 0 want 1", k); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_en();
    test_range_error();
    test_both_ops();
    test_abort();
    test_restart();
    test_reset_mid_write();
`ifdef GBUS_RESP_RANDOM_STALL_EN
    test_random_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
